trace_width_ctrl: RTL and testbench
===================================

Name: trace_width_ctrl

Overview:
Sequences the TPIU trace capture front-end: drives its port-width code and capture enable, and holds capture disabled while the width changes. Watches the front-end's sync flag and, in auto mode, steps through the supported widths until sync is found. Sits between the host config/status registers and the capture front-end. Reports lock state, byte count and sync-loss count.

Parameters:
SETTLE_CYCLES, 64, cycles capture is held disabled after any width change (min 1)
HUNT_TIMEOUT, 32768, cycles without sync before a hunt/lost attempt times out (min 2)

Ports:
clk  in  1  system clock; all logic on rising edge
nRst  in  1  reset, synchronous, active-high
cfgValid  in  1  config request
cfgReady  out  1  config accept; constant 1 out of reset, 0 during reset
cfgEnable  in  1  1 = run capture, 0 = stop (go IDLE)
cfgAuto  in  1  1 = auto width hunt, 0 = fixed width
cfgWidth  in  2  requested width code (bits-1); legal 0,1,2
sync  in  1  sync flag from capture front-end
dvalidIn  in  1  one-cycle strobe per captured output byte
capEnable  out  1  1 = capture front-end running, 0 = held in reset
width  out  2  width code driven to front-end
locked  out  1  1 while in LOCKED
state  out  3  IDLE=0 SETTLE=1 HUNT=2 LOCKED=3 LOST=4
byteCount  out  16  bytes received while LOCKED; wraps
lossCount  out  8  LOCKED->LOST transitions; saturates at 255
cfgErr  out  1  one-cycle pulse when cfgWidth==3 is accepted

Behaviour:
- All outputs registered. Reset values: state=IDLE, width=0, capEnable=0, locked=0, byteCount=0, lossCount=0, cfgErr=0, cfgReady=0 during reset; cfgReady=1 from the first cycle after reset.
- Config handshake: accepted on any edge with cfgValid=1 and cfgReady=1. It overrides every other transition that cycle.
- Accepted config with cfgEnable=0 -> IDLE next cycle, capEnable=0. width is left unchanged.
- Accepted config with cfgEnable=1 -> SETTLE next cycle with capEnable=0, width=cfgWidth, auto mode latched from cfgAuto, settle counter cleared.
- cfgWidth==3: width=2 is latched and cfgErr pulses for exactly 1 cycle.
- Accepting a config does not clear byteCount or lossCount. Only reset clears them.
- IDLE: capEnable=0. Waits for config.
- SETTLE: capEnable=0 for exactly SETTLE_CYCLES cycles (counted from the first SETTLE cycle), then -> HUNT. capEnable=1 from the first HUNT cycle. Timer cleared on entry.
- HUNT: capEnable=1.
  - sync=1 -> LOCKED next cycle.
  - Otherwise the timer increments. When timer reaches HUNT_TIMEOUT-1 with sync=0:
    - auto mode: width advances 0->1->2->0, -> SETTLE.
    - fixed mode: timer clears, stay in HUNT.
- LOCKED: locked=1, capEnable=1.
  - Each dvalidIn=1 cycle increments byteCount (mod 2^16). dvalidIn is ignored in every other state.
  - sync=0 -> LOST next cycle, lossCount+1 (saturating). locked=0 from the first LOST cycle.
- LOST: capEnable=1, timer cleared on entry.
  - sync=1 before timeout -> LOCKED, lossCount unchanged.
  - Timeout at HUNT_TIMEOUT-1 cycles: auto mode -> width advance + SETTLE; fixed mode -> HUNT.
- Simultaneous events:
  - Config beats sync and timeout.
  - sync=1 in the timeout cycle -> lock wins, no width advance.
  - dvalidIn in the same cycle LOCKED->LOST is still counted.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of state.
- Timers sized to hold HUNT_TIMEOUT-1 and SETTLE_CYCLES without overflow.

Test Plan:
All scenarios use SETTLE_CYCLES=4, HUNT_TIMEOUT=16.
1. Reset, then cfgEnable=1, cfgAuto=0, cfgWidth=1 for one cycle -> next cycle state=1, width=1, capEnable=0 for exactly 4 cycles, then state=2, capEnable=1.
2. Fixed mode HUNT, sync pulled high after 10 cycles -> state=3, locked=1 one cycle later. 5 dvalidIn strobes -> byteCount=5.
3. Auto mode, cfgWidth=0, sync held 0 -> after 16 HUNT cycles width=1, state=1. Repeat -> width=2, then width wraps to 0. capEnable=0 during every SETTLE.
4. LOCKED, sync drops -> state=4, lossCount=1, locked=0. sync back after 3 cycles -> state=3, lossCount stays 1. Drop again for 16 cycles in fixed mode -> state=2, lossCount=2.
5. cfgWidth=3 accepted -> width=2, cfgErr high exactly 1 cycle. Config with cfgEnable=0 while LOCKED -> state=0, capEnable=0, byteCount retained.
6. Assert nRst while LOCKED with byteCount=300 -> next cycle all outputs at reset values. cfgValid during reset is ignored.

Source files
------------

// File: rtl/trace_width_ctrl_if.sv
// Host config/status and capture front-end signals of the trace width sequencer.
// The slave modport is the sequencer; the master modport is the host plus front-end side.
interface trace_width_ctrl_if;
    logic        cfgValid;
    logic        cfgReady;
    logic        cfgEnable;
    logic        cfgAuto;
    logic [1:0]  cfgWidth;
    logic        sync;
    logic        dvalidIn;
    logic        capEnable;
    logic [1:0]  width;
    logic        locked;
    logic [2:0]  state;
    logic [15:0] byteCount;
    logic [7:0]  lossCount;
    logic        cfgErr;

    modport master (
        output cfgValid, cfgEnable, cfgAuto, cfgWidth, sync, dvalidIn,
        input  cfgReady, capEnable, width, locked, state, byteCount, lossCount, cfgErr
    );

    modport slave (
        input  cfgValid, cfgEnable, cfgAuto, cfgWidth, sync, dvalidIn,
        output cfgReady, capEnable, width, locked, state, byteCount, lossCount, cfgErr
    );
endinterface

// File: rtl/trace_width_ctrl.sv
// TPIU capture front-end sequencer: drives width/capture enable, settles after width
// changes, hunts for sync (optionally stepping through widths) and tracks lock statistics.
module trace_width_ctrl #(
    parameter int SETTLE_CYCLES = 64,
    parameter int HUNT_TIMEOUT  = 32768
) (
    input logic               clk,
    input logic               nRst,
    trace_width_ctrl_if.slave tw
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        HUNT   = 3'd2,
        LOCKED = 3'd3,
        LOST   = 3'd4
    } state_t;

    // One shared timer serves both the settle window and the hunt/lost timeout.
    localparam int TMAX = (HUNT_TIMEOUT > SETTLE_CYCLES) ? HUNT_TIMEOUT : SETTLE_CYCLES + 1;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] HUNT_LAST   = TW'(HUNT_TIMEOUT - 1);

    state_t        stateQ, stateD;
    logic [TW-1:0] timerQ, timerD;
    logic [1:0]    widthQ, widthD;
    logic          autoQ, autoD;
    logic [15:0]   byteQ, byteD;
    logic [7:0]    lossQ, lossD;
    logic          cfgErrQ, cfgErrD;
    logic          readyQ;
    logic          capEnQ;
    logic          lockedQ;
    logic          cfgAccept;

    assign cfgAccept = tw.cfgValid && readyQ;

    function automatic logic [1:0] nextWidth(input logic [1:0] w);
        return (w >= 2'd2) ? 2'd0 : w + 2'd1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        stateD  = stateQ;
        timerD  = timerQ;
        widthD  = widthQ;
        autoD   = autoQ;
        byteD   = byteQ;
        lossD   = lossQ;
        cfgErrD = 1'b0;

        if (stateQ == LOCKED && tw.dvalidIn) begin
            byteD = byteQ + 16'd1;
        end

        if (cfgAccept) begin
            cfgErrD = (tw.cfgWidth == 2'd3);
            timerD  = '0;
            if (tw.cfgEnable) begin
                stateD = SETTLE;
                widthD = (tw.cfgWidth == 2'd3) ? 2'd2 : tw.cfgWidth;
                autoD  = tw.cfgAuto;
            end else begin
                stateD = IDLE;
            end
        end else begin
            case (stateQ)
                IDLE: begin
                    timerD = '0;
                end
                SETTLE: begin
                    if (timerQ == SETTLE_LAST) begin
                        stateD = HUNT;
                        timerD = '0;
                    end else begin
                        timerD = timerQ + TW'(1);
                    end
                end
                HUNT: begin
                    // A sync seen in the timeout cycle wins over the width step.
                    if (tw.sync) begin
                        stateD = LOCKED;
                        timerD = '0;
                    end else if (timerQ == HUNT_LAST) begin
                        timerD = '0;
                        if (autoQ) begin
                            widthD = nextWidth(widthQ);
                            stateD = SETTLE;
                        end
                    end else begin
                        timerD = timerQ + TW'(1);
                    end
                end
                LOCKED: begin
                    if (!tw.sync) begin
                        stateD = LOST;
                        timerD = '0;
                        if (lossQ != 8'hFF) begin
                            lossD = lossQ + 8'd1;
                        end
                    end
                end
                LOST: begin
                    if (tw.sync) begin
                        stateD = LOCKED;
                        timerD = '0;
                    end else if (timerQ == HUNT_LAST) begin
                        timerD = '0;
                        if (autoQ) begin
                            widthD = nextWidth(widthQ);
                            stateD = SETTLE;
                        end else begin
                            stateD = HUNT;
                        end
                    end else begin
                        timerD = timerQ + TW'(1);
                    end
                end
                default: begin
                    stateD = IDLE;
                    timerD = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and active-high despite its name.
        if (nRst) begin
            stateQ  <= IDLE;
            timerQ  <= '0;
            widthQ  <= 2'd0;
            autoQ   <= 1'b0;
            byteQ   <= 16'd0;
            lossQ   <= 8'd0;
            cfgErrQ <= 1'b0;
            readyQ  <= 1'b0;
            capEnQ  <= 1'b0;
            lockedQ <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            stateQ  <= stateD;
            timerQ  <= timerD;
            widthQ  <= widthD;
            autoQ   <= autoD;
            byteQ   <= byteD;
            lossQ   <= lossD;
            cfgErrQ <= cfgErrD;
            readyQ  <= 1'b1;
            capEnQ  <= (stateD == HUNT) || (stateD == LOCKED) || (stateD == LOST);
            lockedQ <= (stateD == LOCKED);
        end
    end

    assign tw.cfgReady  = readyQ;
    assign tw.capEnable = capEnQ;
    assign tw.width     = widthQ;
    assign tw.locked    = lockedQ;
    assign tw.state     = stateQ;
    assign tw.byteCount = byteQ;
    assign tw.lossCount = lossQ;
    assign tw.cfgErr    = cfgErrQ;

endmodule

// File: tb/tb_trace_width_ctrl.sv
// Scoreboard bench for trace_width_ctrl: expectations are queued as stimulus is driven
// and compared one cycle later, #1 after the rising edge.
module tb_trace_width_ctrl;

    localparam int SETTLE = 4;
    localparam int TOUT   = 16;

    typedef enum int {S_STATE, S_WIDTH, S_CAPEN, S_LOCKED, S_BYTES, S_LOSS, S_ERR, S_READY} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic nRst;
    int   testsRun;
    int   testsFailed;
    int   expBytes;
    int   expLoss;
    int   expWidth;
    exp_t sbq[$];

    trace_width_ctrl_if tw ();

    trace_width_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .HUNT_TIMEOUT (TOUT)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .tw  (tw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] readOut(input sel_e sel);
        case (sel)
            S_STATE:  return 16'(tw.state);
            S_WIDTH:  return 16'(tw.width);
            S_CAPEN:  return 16'(tw.capEnable);
            S_LOCKED: return 16'(tw.locked);
            S_BYTES:  return tw.byteCount;
            S_LOSS:   return 16'(tw.lossCount);
            S_ERR:    return 16'(tw.cfgErr);
            default:  return 16'(tw.cfgReady);
        endcase
    endfunction

    task automatic expectOut(input string tag, input sel_e sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = 16'(val);
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check(e.tag, readOut(e.sel), e.val);
            end
        end
    endtask

    task automatic expectReset(input string tag);
        expectOut({tag, ".state"},  S_STATE, 0);
        expectOut({tag, ".width"},  S_WIDTH, 0);
        expectOut({tag, ".capEn"},  S_CAPEN, 0);
        expectOut({tag, ".locked"}, S_LOCKED, 0);
        expectOut({tag, ".bytes"},  S_BYTES, 0);
        expectOut({tag, ".loss"},   S_LOSS, 0);
        expectOut({tag, ".err"},    S_ERR, 0);
        expectOut({tag, ".ready"},  S_READY, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expBytes    = 0;
        expLoss     = 0;
        nRst        = 1'b1;
        tw.cfgValid  = 1'b0;
        tw.cfgEnable = 1'b0;
        tw.cfgAuto   = 1'b0;
        tw.cfgWidth  = 2'd0;
        tw.sync      = 1'b0;
        tw.dvalidIn  = 1'b0;
        step(1);
        expectReset("rst");
        step(1);
        nRst = 1'b0;
        expectOut("ready_after_rst", S_READY, 1);
        expectOut("idle_after_rst", S_STATE, 0);
        step(1);

        // Fixed-mode config, width 1: four settle cycles then hunt
        tw.cfgValid = 1'b1; tw.cfgEnable = 1'b1; tw.cfgAuto = 1'b0; tw.cfgWidth = 2'd1;
        expectOut("cfg1.state", S_STATE, 1);
        expectOut("cfg1.width", S_WIDTH, 1);
        expectOut("cfg1.capEn", S_CAPEN, 0);
        step(1);
        tw.cfgValid = 1'b0;
        for (int k = 0; k < SETTLE - 1; k++) begin
            expectOut("settle.state", S_STATE, 1);
            expectOut("settle.capEn", S_CAPEN, 0);
            step(1);
        end
        expectOut("hunt.state", S_STATE, 2);
        expectOut("hunt.capEn", S_CAPEN, 1);
        step(1);
        for (int k = 0; k < 9; k++) begin
            expectOut("hunt_wait.state", S_STATE, 2);
            step(1);
        end
        tw.sync = 1'b1;
        expectOut("lock.state", S_STATE, 3);
        expectOut("lock.locked", S_LOCKED, 1);
        step(1);
        for (int k = 0; k < 5; k++) begin
            tw.dvalidIn = 1'b1;
            expBytes++;
            step(1);
            tw.dvalidIn = 1'b0;
            step(1);
        end
        expectOut("bytes5", S_BYTES, expBytes);
        step(1);

        // Sync loss, quick relock, then a fixed-mode lost timeout back to hunt
        tw.sync = 1'b0;
        tw.dvalidIn = 1'b1;
        expBytes++;
        expLoss++;
        expectOut("lost.state", S_STATE, 4);
        expectOut("lost.loss", S_LOSS, expLoss);
        expectOut("lost.locked", S_LOCKED, 0);
        expectOut("lost.capEn", S_CAPEN, 1);
        expectOut("lost.bytes_edge", S_BYTES, expBytes);
        step(1);
        expectOut("lost_ignore.bytes", S_BYTES, expBytes);
        step(1);
        tw.dvalidIn = 1'b0;
        step(1);
        tw.sync = 1'b1;
        expectOut("relock.state", S_STATE, 3);
        expectOut("relock.loss", S_LOSS, expLoss);
        step(1);
        tw.sync = 1'b0;
        expLoss++;
        expectOut("lost2.state", S_STATE, 4);
        step(1);
        for (int k = 0; k < TOUT - 1; k++) begin
            expectOut("lost2_wait.state", S_STATE, 4);
            step(1);
        end
        expectOut("lost_tout.state", S_STATE, 2);
        expectOut("lost_tout.loss", S_LOSS, expLoss);
        step(1);

        // Illegal width code clamps to 2 and flags for one cycle
        tw.cfgValid = 1'b1; tw.cfgEnable = 1'b1; tw.cfgAuto = 1'b0; tw.cfgWidth = 2'd3;
        expectOut("w3.width", S_WIDTH, 2);
        expectOut("w3.err", S_ERR, 1);
        expectOut("w3.state", S_STATE, 1);
        step(1);
        tw.cfgValid = 1'b0;
        expectOut("w3.err_clear", S_ERR, 0);
        step(1);
        step(2);
        expectOut("w3.hunt", S_STATE, 2);
        step(1);
        tw.sync = 1'b1;
        expectOut("w3.lock", S_STATE, 3);
        step(1);
        tw.cfgValid = 1'b1; tw.cfgEnable = 1'b0;
        expectOut("stop.state", S_STATE, 0);
        expectOut("stop.capEn", S_CAPEN, 0);
        expectOut("stop.locked", S_LOCKED, 0);
        expectOut("stop.width", S_WIDTH, 2);
        expectOut("stop.bytes", S_BYTES, expBytes);
        step(1);
        tw.cfgValid = 1'b0;
        tw.sync = 1'b0;
        step(1);

        // Auto hunt from width 0 stepping 0->1->2->0
        tw.cfgValid = 1'b1; tw.cfgEnable = 1'b1; tw.cfgAuto = 1'b1; tw.cfgWidth = 2'd0;
        expWidth = 0;
        expectOut("auto.width", S_WIDTH, expWidth);
        expectOut("auto.state", S_STATE, 1);
        step(1);
        tw.cfgValid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < SETTLE - 1; k++) begin
                expectOut("auto_settle.capEn", S_CAPEN, 0);
                step(1);
            end
            expectOut("auto_hunt.state", S_STATE, 2);
            step(1);
            for (int k = 0; k < TOUT - 1; k++) begin
                expectOut("auto_hunt_wait.state", S_STATE, 2);
                step(1);
            end
            expWidth = (expWidth + 1) % 3;
            expectOut("auto_step.state", S_STATE, 1);
            expectOut("auto_step.width", S_WIDTH, expWidth);
            expectOut("auto_step.capEn", S_CAPEN, 0);
            step(1);
        end

        // Sync arriving in the timeout cycle locks without a width step
        step(SETTLE - 1);
        step(1);
        step(TOUT - 1);
        tw.sync = 1'b1;
        expectOut("tie.state", S_STATE, 3);
        expectOut("tie.width", S_WIDTH, expWidth);
        step(1);

        // Loss counter saturation
        for (int i = 0; i < 260; i++) begin
            tw.sync = 1'b0;
            if (expLoss < 255) expLoss++;
            step(1);
            tw.sync = 1'b1;
            step(1);
        end
        expectOut("loss_sat", S_LOSS, expLoss);
        expectOut("loss_sat.state", S_STATE, 3);
        step(1);

        // Reset while locked with 300 bytes; cfgValid during reset is ignored
        while (expBytes < 300) begin
            tw.dvalidIn = 1'b1;
            expBytes++;
            step(1);
        end
        tw.dvalidIn = 1'b0;
        expectOut("bytes300", S_BYTES, 300);
        step(1);
        nRst = 1'b1;
        tw.cfgValid = 1'b1; tw.cfgEnable = 1'b1; tw.cfgAuto = 1'b0; tw.cfgWidth = 2'd1;
        expectReset("midrst");
        step(1);
        expectOut("midrst_hold.state", S_STATE, 0);
        expectOut("midrst_hold.ready", S_READY, 0);
        step(1);
        nRst = 1'b0;
        tw.cfgValid = 1'b0;
        expectOut("post_rst.state", S_STATE, 0);
        expectOut("post_rst.width", S_WIDTH, 0);
        expectOut("post_rst.ready", S_READY, 1);
        step(1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
